lfsr_word_arbiter: RTL and testbench
====================================

// Module: lfsr_word_arbiter
// PURPOSE
//  Pseudo-random word source shared by several requesters in the SPI_LCD
//  design, e.g. test-pattern colour and noise generators.
//  Owns an internal Fibonacci LFSR and sequences it: shifts it one bit per
//  clock, packs the bits into WORD_BITS words, and hands each word to exactly
//  one requester using round-robin arbitration. Supports runtime reseeding.
// PARAMETERS
//  NUM_BITS  10       LFSR length (>=2)
//  TAPS      10'h240  feedback tap mask, bit i set = sr[i] feeds XOR
//  SEED      10'd1    reset seed and substitute for an all-zero seed_in
//  WORD_BITS 16       bits packed per output word (>=2)
//  NUM_REQ   2        number of requesters (1..8)
// PORTS
//  clk         in   1          single clock, rising edge
//  rst         in   1          asynchronous, active-high reset
//  reseed      in   1          one-cycle pulse: load seed_in, restart word
//  seed_in     in   NUM_BITS   new seed, sampled when reseed=1
//  req         in   NUM_REQ    per-requester word request (level)
//  gnt         out  NUM_REQ    one-hot grant; word_out is taken that cycle
//  word_out    out  WORD_BITS  current packed word
//  word_valid  out  1          word_out is complete and unclaimed
//  busy        out  1          filling a word (state FILL)
// BEHAVIOUR
//  Reset, asynchronous:
//   - Registers: sr=SEED, acc=0, bit_cnt=0, rr_ptr=NUM_REQ-1, state=FILL.
//   - Outputs: gnt=0, word_out=0, word_valid=0, busy=1.
//  LFSR step, FILL only:
//   - Feedback fb = ^(sr & TAPS). Shift sr <= {sr[NUM_BITS-2:0], fb}.
//   - Packing is MSB-first from the pre-shift sr: acc <= {acc[WORD_BITS-2:0], sr[NUM_BITS-1]}.
//   - The LFSR holds in READY.
//  FSM:
//   - FILL: one step per clock while bit_cnt counts 0..WORD_BITS-1. At
//     bit_cnt==WORD_BITS-1, go to READY; word_out <= the completed word.
//   - READY: word_valid=1, busy=0. With req==0, stay.
//   - READY with req!=0: the arbiter picks the first set req[] searching from
//     rr_ptr+1 and wrapping. gnt is combinational from state, rr_ptr and req.
//     The transfer is on that edge: rr_ptr <= winner, bit_cnt <= 0, state <= FILL.
//  Latency and throughput:
//   - The first word is valid WORD_BITS clocks after reset release.
//   - A new word is valid WORD_BITS clocks after each grant.
//   - Maximum rate is 1 word per WORD_BITS+1 clocks.
//  Grant rules:
//   - gnt is at most one-hot, and is 0 outside READY.
//   - Each word is granted exactly once.
//   - req may drop before a grant with no side effect.
//  Reseed, highest priority, any state:
//   - Effect next edge: sr <= (seed_in==0) ? SEED : seed_in, acc <= 0, bit_cnt <= 0, state <= FILL.
//   - word_valid drops. A word pending in READY is discarded.
//   - gnt is forced to 0 in the reseed cycle. rr_ptr is unchanged.
//  Lock-up guard: sr never becomes all-zero via reseed.
//  rst mid-fill or mid-grant: immediate return to the reset values above.
// TESTING
//  1) Reset, defaults, req=0:
//     - word_valid rises on clock 16 after reset release; word_out=16'h0040.
//     - word_out then holds indefinitely; gnt stays 0.
//  2) req=2'b11 held:
//     - Grants alternate 01,10,01,...; first grant goes to req0.
//     - Consecutive gnt pulses are exactly 17 clocks apart.
//  3) req=2'b10 only:
//     - Every grant goes to req1. rr_ptr wrap is correct: req0 added later
//       receives the next grant.
//  4) reseed=1 with seed_in=10'h001 in the same cycle as a READY grant:
//     - gnt=0 in that cycle, word_valid drops.
//     - The next word is again 16'h0040.
//  5) reseed with seed_in=0: behaves as seed SEED; the next word is 16'h0040.
//  6) rst asserted mid-FILL (bit_cnt=7):
//     - Outputs go to reset values without waiting for clk.
//     - After release, the first word is 16'h0040.

Source files
------------

// File: rtl/lfsr_word_arbiter.sv
// Fibonacci LFSR word source: packs LFSR output bits MSB-first into words and
// hands each completed word to one requester under round-robin arbitration.
module lfsr_word_arbiter #(
    parameter int unsigned              NUM_BITS  = 10,
    parameter logic [NUM_BITS-1:0]      TAPS      = 10'h240,
    parameter logic [NUM_BITS-1:0]      SEED      = 10'd1,
    parameter int unsigned              WORD_BITS = 16,
    parameter int unsigned              NUM_REQ   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 reseed_i,
    input  logic [NUM_BITS-1:0]  seed_in_i,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [WORD_BITS-1:0] word_out_o,
    output logic                 word_valid_o,
    output logic                 busy_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BITS - 1);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_e;

    state_e               state_q;
    logic [NUM_BITS-1:0]  sr_q;
    logic [NUM_BITS-1:0]  sr_d;
    logic [WORD_BITS-1:0] acc_q;
    logic [WORD_BITS-1:0] acc_d;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [WORD_BITS-1:0] word_q;
    logic                 valid_q;
    logic                 busy_q;

    logic                 found_c;
    logic [PTR_W-1:0]     winner_c;
    logic [NUM_REQ-1:0]   gnt_c;

    // One LFSR step and the accumulator with the outgoing MSB appended
    always_comb begin
        sr_d  = {sr_q[NUM_BITS-2:0], ^(sr_q & TAPS)};
        acc_d = {acc_q[WORD_BITS-2:0], sr_q[NUM_BITS-1]};
    end

    // Round-robin search starting just after the last winner
    always_comb begin
        int idx;
        idx      = 0;
        found_c  = 1'b0;
        winner_c = rr_ptr_q;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            idx = (int'(rr_ptr_q) + i) % int'(NUM_REQ);
            if (!found_c && req_i[PTR_W'(idx)]) begin
                found_c  = 1'b1;
                winner_c = PTR_W'(idx);
            end
        end
        gnt_c = '0;
        if (found_c && (state_q == READY) && !reseed_i) begin
            gnt_c = NUM_REQ'(1) << winner_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= FILL;
            sr_q      <= SEED;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            rr_ptr_q  <= PTR_RST;
            word_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else if (reseed_i) begin
            // An all-zero seed would lock the LFSR, so fall back to SEED
            state_q   <= FILL;
            sr_q      <= (seed_in_i == '0) ? SEED : seed_in_i;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    sr_q  <= sr_d;
                    acc_q <= acc_d;
                    if (bit_cnt_q == LAST_CNT) begin
                        state_q   <= READY;
                        word_q    <= acc_d;
                        bit_cnt_q <= '0;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                READY: begin
                    if (found_c) begin
                        state_q   <= FILL;
                        rr_ptr_q  <= winner_c;
                        bit_cnt_q <= '0;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign gnt_o        = gnt_c;
    assign word_out_o   = word_q;
    assign word_valid_o = valid_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_lfsr_word_arbiter.sv
// Scoreboard bench for lfsr_word_arbiter: stimulus queues expected words and
// grants, a negedge monitor pops and compares them as the DUT presents them.
module tb_lfsr_word_arbiter;

    logic        clk;
    logic        rst;
    logic        reseed;
    logic [9:0]  seed_in;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [15:0] word_out;
    logic        word_valid;
    logic        busy;

    typedef struct packed {
        logic [1:0]  g;
        logic [15:0] w;
    } gexp_t;

    logic [15:0] exp_word_q[$];
    gexp_t       exp_gnt_q[$];

    int          checks = 0;
    int          errors = 0;
    int          n_gnt = 0;
    int          cyc = 0;
    int          last_gnt_cyc = -1;
    bit          spacing_on = 1'b0;
    logic        prev_valid = 1'b0;
    logic [9:0]  m_sr;
    logic [15:0] pend;

    lfsr_word_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reseed_i     (reseed),
        .seed_in_i    (seed_in),
        .req_i        (req),
        .gnt_o        (gnt),
        .word_out_o   (word_out),
        .word_valid_o (word_valid),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: 16 steps from m_sr, bits packed MSB-first
    function automatic logic [15:0] step_word();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w    = {w[14:0], m_sr[9]};
            m_sr = {m_sr[8:0], ^(m_sr & 10'h240)};
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_gnts(input int target);
        int n;
        n = 0;
        while (n_gnt < target && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n_gnt < target) chk("grant timeout", 32'(n_gnt), 32'(target));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: completed words on valid rise, granted words on any gnt
    always @(negedge clk) begin
        cyc++;
        if (word_valid && !prev_valid) begin
            checks++;
            if (exp_word_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected word: got %0h expected none", word_out);
            end else begin
                logic [15:0] ew;
                ew = exp_word_q.pop_front();
                if (word_out !== ew) begin
                    errors++;
                    $display("FAIL word: got %0h expected %0h", word_out, ew);
                end
            end
        end
        prev_valid = word_valid;
        if (gnt !== 2'b00) begin
            checks++;
            if (exp_gnt_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected gnt: got %b expected 00", gnt);
            end else begin
                gexp_t e;
                e = exp_gnt_q.pop_front();
                if (gnt !== e.g || word_out !== e.w || word_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL grant: got gnt=%b word=%0h valid=%b expected gnt=%b word=%0h valid=1",
                             gnt, word_out, word_valid, e.g, e.w);
                end
            end
            if (spacing_on && last_gnt_cyc >= 0) begin
                checks++;
                if (cyc - last_gnt_cyc != 17) begin
                    errors++;
                    $display("FAIL grant spacing: got %0d expected 17", cyc - last_gnt_cyc);
                end
            end
            last_gnt_cyc = cyc;
            n_gnt++;
        end
    end

    initial begin
        int base;
        rst     = 1'b1;
        reseed  = 1'b0;
        seed_in = '0;
        req     = 2'b00;

        // 1) reset values and first word
        #3;
        chk("reset gnt", 32'(gnt), 0);
        chk("reset word_out", 32'(word_out), 0);
        chk("reset valid", 32'(word_valid), 0);
        chk("reset busy", 32'(busy), 1);
        m_sr = 10'd1;
        pend = step_word();
        exp_word_q.push_back(pend);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick(15);
        chk("valid before clock 16", 32'(word_valid), 0);
        tick(1);
        chk("valid at clock 16", 32'(word_valid), 1);
        chk("busy at clock 16", 32'(busy), 0);
        chk("first word", 32'(word_out), 32'h0040);
        tick(20);
        chk("word holds", 32'(word_out), 32'h0040);
        chk("gnt idle", 32'(gnt), 0);

        // 2) both requesting: alternate 01,10,... every 17 clocks
        last_gnt_cyc = -1;
        spacing_on   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_gnt_q.push_back(gexp_t'{(k % 2 == 0) ? 2'b01 : 2'b10, pend});
            pend = step_word();
            exp_word_q.push_back(pend);
        end
        base = n_gnt;
        req  = 2'b11;
        wait_gnts(base + 4);
        req = 2'b00;
        tick(20);

        // 3) req1 only, then req0 joins and wins via wrap
        last_gnt_cyc = -1;
        exp_gnt_q.push_back(gexp_t'{2'b10, pend});
        pend = step_word();
        exp_word_q.push_back(pend);
        exp_gnt_q.push_back(gexp_t'{2'b10, pend});
        pend = step_word();
        exp_word_q.push_back(pend);
        exp_gnt_q.push_back(gexp_t'{2'b01, pend});
        pend = step_word();
        exp_word_q.push_back(pend);
        base = n_gnt;
        req  = 2'b10;
        wait_gnts(base + 2);
        req = 2'b11;
        wait_gnts(base + 3);
        req = 2'b00;
        tick(20);
        spacing_on = 1'b0;

        // 4) reseed in the same cycle as a would-be grant
        chk("ready before reseed", 32'(word_valid), 1);
        req     = 2'b01;
        reseed  = 1'b1;
        seed_in = 10'h001;
        #3;
        chk("gnt during reseed", 32'(gnt), 0);
        @(posedge clk);
        #1;
        reseed = 1'b0;
        req    = 2'b00;
        chk("valid after reseed", 32'(word_valid), 0);
        chk("busy after reseed", 32'(busy), 1);
        m_sr = 10'h001;
        pend = step_word();
        exp_word_q.push_back(pend);
        tick(15);
        chk("valid 15 after reseed", 32'(word_valid), 0);
        tick(1);
        chk("valid 16 after reseed", 32'(word_valid), 1);
        chk("word after reseed", 32'(word_out), 32'h0040);

        // 5) rr_ptr kept across reseed (req1 wins), then zero seed mid-fill
        exp_gnt_q.push_back(gexp_t'{2'b10, pend});
        pend = step_word();
        base = n_gnt;
        req  = 2'b11;
        wait_gnts(base + 1);
        req = 2'b00;
        tick(5);
        reseed  = 1'b1;
        seed_in = 10'h000;
        @(posedge clk);
        #1;
        reseed = 1'b0;
        chk("busy after zero reseed", 32'(busy), 1);
        m_sr = 10'd1;
        pend = step_word();
        exp_word_q.push_back(pend);
        tick(16);
        chk("valid after zero reseed", 32'(word_valid), 1);
        chk("word after zero reseed", 32'(word_out), 32'h0040);

        // 6) asynchronous reset at bit_cnt=7
        exp_gnt_q.push_back(gexp_t'{2'b01, pend});
        pend = step_word();
        base = n_gnt;
        req  = 2'b01;
        wait_gnts(base + 1);
        req = 2'b00;
        repeat (7) @(posedge clk);
        #1;
        chk("word before mid-fill rst", 32'(word_out), 32'h0040);
        #2 rst = 1'b1;
        #1;
        chk("rst word_out", 32'(word_out), 0);
        chk("rst valid", 32'(word_valid), 0);
        chk("rst busy", 32'(busy), 1);
        chk("rst gnt", 32'(gnt), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_sr = 10'd1;
        pend = step_word();
        exp_word_q.push_back(pend);
        tick(16);
        chk("valid after rst", 32'(word_valid), 1);
        chk("word after rst", 32'(word_out), 32'h0040);

        tick(3);
        chk("word queue drained", 32'(exp_word_q.size()), 0);
        chk("gnt queue drained", 32'(exp_gnt_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
